layer_norm_row_driver: RTL and testbench



---
 rtl/layer_norm_row_driver_pkg.sv | 31 +++
 rtl/layer_norm_row_driver_row_beat_counter.sv | 60 ++++++
 rtl/layer_norm_row_driver.sv | 179 +++++++++++++++++
 tb/tb_layer_norm_row_driver.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_norm_row_driver_pkg.sv
// Shared types and constants for the LayerNorm row driver.
package layer_norm_row_driver_pkg;

  localparam int DEF_D_MODEL    = 128;
  localparam int DEF_X_WIDTH    = 16;
  localparam int DEF_Y_WIDTH    = 16;
  localparam int DEF_BEAT_ELEMS = 8;
  localparam int DEF_MAX_ROWS   = 64;
  localparam int DEF_ADDR_WIDTH = 10;

  // Ceil-log2 that never returns 0, so single-entry counters still get a bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  localparam int BEATS     = DEF_D_MODEL / DEF_BEAT_ELEMS;
  localparam int X_SLICE_W = DEF_BEAT_ELEMS * DEF_X_WIDTH;
  localparam int Y_SLICE_W = DEF_BEAT_ELEMS * DEF_Y_WIDTH;
  localparam int BEAT_W    = clog2_min1(BEATS);
  localparam int ROW_W     = clog2_min1(DEF_MAX_ROWS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_STORE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/layer_norm_row_driver_row_beat_counter.sv
// Nested row/beat counter; yields buffer word address row*N_BEATS+beat.
// The same counter walks the input buffer in LOAD and the output buffer in STORE.
module layer_norm_row_driver_row_beat_counter
  import layer_norm_row_driver_pkg::*;
#(
  parameter int N_BEATS    = BEATS,
  parameter int RW         = ROW_W,
  parameter int BW         = BEAT_W,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  beat_inc,
  input  logic                  row_inc,
  input  logic [RW-1:0]         num_rows,
  output logic [BW-1:0]         beat,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last_beat,
  output logic                  last_row
);

  logic [RW-1:0] row_q, row_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [RW:0]   row_nxt;

  // Flags and address are pure functions of the current count.
  always_comb begin
    beat      = beat_q;
    last_beat = (beat_q == BW'(N_BEATS - 1));
    row_nxt   = {1'b0, row_q} + (RW+1)'(1);
    last_row  = (row_nxt >= {1'b0, num_rows});
    addr      = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(N_BEATS) + ADDR_WIDTH'(beat_q);
  end

  // Next count: beat wraps at the last beat; row only advances on request.
  always_comb begin
    beat_d = beat_q;
    row_d  = row_q;
    if (clr) begin
      beat_d = '0;
      row_d  = '0;
    end else begin
      if (beat_inc) beat_d = last_beat ? '0 : beat_q + BW'(1);
      if (row_inc)  row_d  = row_q + RW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      row_q  <= '0;
    end else begin
      beat_q <= beat_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/layer_norm_row_driver.sv
// Streams rows from the activation buffer into LayerNorm and writes the
// normalized rows back, one row at a time.
module layer_norm_row_driver
  import layer_norm_row_driver_pkg::*;
#(
  parameter int D_MODEL    = DEF_D_MODEL,
  parameter int X_WIDTH    = DEF_X_WIDTH,
  parameter int Y_WIDTH    = DEF_Y_WIDTH,
  parameter int BEAT_ELEMS = DEF_BEAT_ELEMS,
  parameter int MAX_ROWS   = DEF_MAX_ROWS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_start,
  input  logic [6:0]                    cmd_num_rows,
  output logic                          cmd_busy,
  output logic                          cmd_done,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic [BEAT_ELEMS*X_WIDTH-1:0] rd_data,
  output logic                          ln_start,
  output logic [D_MODEL*X_WIDTH-1:0]    ln_x_flat,
  input  logic                          ln_busy,
  input  logic                          ln_done,
  input  logic [D_MODEL*Y_WIDTH-1:0]    ln_y_flat,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [BEAT_ELEMS*Y_WIDTH-1:0] wr_data
);

  localparam int N_BEATS = D_MODEL / BEAT_ELEMS;
  localparam int XS_W    = BEAT_ELEMS * X_WIDTH;
  localparam int YS_W    = BEAT_ELEMS * Y_WIDTH;
  localparam int BW      = clog2_min1(N_BEATS);
  localparam int RW      = clog2_min1(MAX_ROWS + 1);

  state_e                     state_q, state_d;
  logic [D_MODEL*X_WIDTH-1:0] x_q, x_d;
  logic [D_MODEL*Y_WIDTH-1:0] y_q, y_d;
  logic [RW-1:0]              num_rows_q, num_rows_d;
  logic                       load_tail_q, load_tail_d;
  logic                       cap_vld_q, cap_vld_d;
  logic [BW-1:0]              cap_beat_q, cap_beat_d;

  logic                  cnt_clr, beat_inc, row_inc;
  logic [BW-1:0]         beat;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  last_beat, last_row;

  layer_norm_row_driver_row_beat_counter #(
    .N_BEATS    (N_BEATS),
    .RW         (RW),
    .BW         (BW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .beat_inc  (beat_inc),
    .row_inc   (row_inc),
    .num_rows  (num_rows_q),
    .beat      (beat),
    .addr      (addr),
    .last_beat (last_beat),
    .last_row  (last_row)
  );

  // Shared address and data steering; strobes decide which side is live.
  always_comb begin
    rd_addr   = addr;
    wr_addr   = addr;
    wr_data   = y_q[32'(beat) * YS_W +: YS_W];
    ln_x_flat = x_q;
    cmd_busy  = (state_q != ST_IDLE);
  end

  // Sequencer: next state, strobes, and the beat-capture pipeline into x.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    num_rows_d  = num_rows_q;
    load_tail_d = load_tail_q;
    cap_vld_d   = 1'b0;
    cap_beat_d  = cap_beat_q;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    ln_start    = 1'b0;
    cmd_done    = 1'b0;
    cnt_clr     = 1'b0;
    beat_inc    = 1'b0;
    row_inc     = 1'b0;

    // Read data returns one cycle after rd_en; land it in the slice it was read for.
    if (cap_vld_q) x_d[32'(cap_beat_q) * XS_W +: XS_W] = rd_data;

    case (state_q)
      ST_IDLE: begin
        cnt_clr     = 1'b1;
        load_tail_d = 1'b0;
        if (cmd_start) begin
          if (cmd_num_rows == '0) begin
            state_d = ST_DONE;
          end else begin
            num_rows_d = (32'(cmd_num_rows) > MAX_ROWS) ? RW'(MAX_ROWS) : RW'(cmd_num_rows);
            state_d    = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        // N_BEATS read cycles, then one tail cycle for the last beat to land.
        if (!load_tail_q) begin
          rd_en      = 1'b1;
          beat_inc   = 1'b1;
          cap_vld_d  = 1'b1;
          cap_beat_d = beat;
          if (last_beat) load_tail_d = 1'b1;
        end else begin
          load_tail_d = 1'b0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!ln_busy) begin
          ln_start = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Only the first done cycle is taken; later ones land in STORE and are ignored.
        if (ln_done) begin
          y_d     = ln_y_flat;
          state_d = ST_STORE;
        end
      end
      ST_STORE: begin
        wr_en    = 1'b1;
        beat_inc = 1'b1;
        if (last_beat) begin
          if (last_row) begin
            state_d = ST_DONE;
          end else begin
            row_inc = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        cmd_done = 1'b1;
        cnt_clr  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      num_rows_q  <= '0;
      load_tail_q <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_beat_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      num_rows_q  <= num_rows_d;
      load_tail_q <= load_tail_d;
      cap_vld_q   <= cap_vld_d;
      cap_beat_q  <= cap_beat_d;
    end
  end

endmodule

// File: tb/tb_layer_norm_row_driver.sv
// Directed bench: buffer/LayerNorm models plus an event scoreboard of the
// read/start/write sequence every command must produce.
module tb_layer_norm_row_driver;
  import layer_norm_row_driver_pkg::*;

  localparam int DM = DEF_D_MODEL;
  localparam int XW = DEF_X_WIDTH;
  localparam int YW = DEF_Y_WIDTH;
  localparam int BE = DEF_BEAT_ELEMS;
  localparam int MR = DEF_MAX_ROWS;
  localparam int AW = DEF_ADDR_WIDTH;
  localparam int XS = X_SLICE_W;
  localparam int YS = Y_SLICE_W;
  localparam int K_RD = 0, K_LN = 1, K_WR = 2;

  typedef struct {
    int kind;
    int addr;
    int row;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_start = 1'b0;
  logic [6:0]        cmd_num_rows = '0;
  logic              cmd_busy, cmd_done, rd_en, ln_start, wr_en;
  logic [AW-1:0]     rd_addr, wr_addr;
  logic [XS-1:0]     rd_data = '0;
  logic [DM*XW-1:0]  ln_x_flat;
  logic              ln_busy = 1'b0;
  logic              ln_done;
  logic [DM*YW-1:0]  ln_y_flat;
  logic [YS-1:0]     wr_data;

  int checks = 0, errors = 0, cyc = 0;
  int n_rd = 0, n_wr = 0, n_ln = 0, last_ln_cyc = 0;
  int last_rd_cyc = 0, last_wr_cyc = 0;
  ev_t q[$];
  bit in_wait = 0;
  logic [DM*XW-1:0] x_snap = '0;
  bit first_wr_seen = 0;
  logic [YS-1:0] first_wr = '0;

  layer_norm_row_driver dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_num_rows(cmd_num_rows),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .ln_start(ln_start), .ln_x_flat(ln_x_flat), .ln_busy(ln_busy),
    .ln_done(ln_done), .ln_y_flat(ln_y_flat), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer word k holds a ramp: element j = k*BE + j.
  function automatic logic [XS-1:0] beat_word(input int k);
    logic [XS-1:0] w;
    for (int j = 0; j < BE; j++) w[j*XW +: XW] = XW'(k*BE + j);
    return w;
  endfunction

  function automatic logic [DM*XW-1:0] row_x(input int r);
    logic [DM*XW-1:0] x;
    for (int b = 0; b < BEATS; b++) x[b*XS +: XS] = beat_word(r*BEATS + b);
    return x;
  endfunction

  function automatic logic [DM*YW-1:0] add_k(input logic [DM*XW-1:0] x, input int k);
    logic [DM*YW-1:0] y;
    for (int e = 0; e < DM; e++) y[e*YW +: YW] = YW'(int'(x[e*XW +: XW]) + k);
    return y;
  endfunction

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int count_bad(input logic [DM*XW-1:0] a, input logic [DM*XW-1:0] b);
    int n = 0;
    for (int e = 0; e < DM; e++) if (a[e*XW +: XW] !== b[e*XW +: XW]) n++;
    return n;
  endfunction

  // Input buffer: one-cycle read latency, poison when not read.
  always @(posedge clk) rd_data <= rd_en ? beat_word(int'(rd_addr)) : {BE{16'hDEAD}};

  // LayerNorm model: y = x+1 on the first done cycle, a different value on
  // any extra done cycles so a late re-capture shows up in the write data.
  int ln_lat = 40, ln_len = 1, ln_cnt = 0;
  logic [DM*YW-1:0] y_good = '0, y_bad = '0;
  always @(posedge clk) begin
    if (ln_start) begin
      ln_cnt <= 1;
      y_good <= add_k(ln_x_flat, 1);
      y_bad  <= add_k(ln_x_flat, 'h55);
    end else if (ln_cnt != 0 && ln_cnt < ln_lat + ln_len - 1) ln_cnt <= ln_cnt + 1;
    else ln_cnt <= 0;
  end
  assign ln_done   = (ln_cnt != 0) && (ln_cnt >= ln_lat) && (ln_cnt < ln_lat + ln_len);
  assign ln_y_flat = (ln_cnt == ln_lat) ? y_good : y_bad;

  task automatic take(input int kind, input string nm, output ev_t e, output bit ok);
    ok = 0;
    e = '{kind: -1, addr: -1, row: -1};
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected strobe got=1 exp=0 (cycle %0d)", nm, cyc);
    end else begin
      e = q.pop_front();
      ok = 1;
      if (e.kind != kind) begin
        errors++;
        $display("FAIL %s_order got kind=%0d exp kind=%0d (cycle %0d)", nm, kind, e.kind, cyc);
      end
    end
  endtask

  // Compare process: every strobe must be the next expected event.
  always begin
    ev_t e;
    bit ok;
    logic [DM*YW-1:0] ey;
    @(negedge clk);
    #1;
    if (!rst) begin
      if (in_wait && !ln_start) check("ln_x_stable_bad_elems", count_bad(ln_x_flat, x_snap), 0);
      if (rd_en) begin
        n_rd++;
        take(K_RD, "rd", e, ok);
        if (ok) begin
          check("rd_addr", rd_addr, e.addr);
          if (e.addr % BEATS != 0) check("rd_gap", cyc - last_rd_cyc, 1);
        end
        last_rd_cyc = cyc;
      end
      if (ln_start) begin
        n_ln++;
        last_ln_cyc = cyc;
        take(K_LN, "ln_start", e, ok);
        check("ln_start_while_busy", ln_busy, 0);
        if (ok) check("ln_x_bad_elems", count_bad(ln_x_flat, row_x(e.row)), 0);
        in_wait = 1;
        x_snap  = ln_x_flat;
      end
      if (wr_en) begin
        n_wr++;
        in_wait = 0;
        if (!first_wr_seen) begin
          first_wr_seen = 1;
          first_wr = wr_data;
        end
        take(K_WR, "wr", e, ok);
        if (ok) begin
          check("wr_addr", wr_addr, e.addr);
          ey = add_k(row_x(e.row), 1);
          check("wr_data", wr_data, ey[(e.addr % BEATS)*YS +: YS]);
          if (e.addr % BEATS != 0) check("wr_gap", cyc - last_wr_cyc, 1);
        end
        last_wr_cyc = cyc;
      end
    end
  end

  task automatic run_cmd(input int n, input int t, input int len, input int busy, input int poke,
                         output int acc, output int lat, output int dl, output int dr, output int dw);
    int neff, rd0, wr0, ln0, off;
    bit got;
    ln_lat = t;
    ln_len = len;
    neff = (n > MR) ? MR : n;
    rd0 = n_rd; wr0 = n_wr; ln0 = n_ln;
    for (int r = 0; r < neff; r++) begin
      for (int b = 0; b < BEATS; b++) q.push_back('{kind: K_RD, addr: r*BEATS + b, row: r});
      q.push_back('{kind: K_LN, addr: -1, row: r});
      for (int b = 0; b < BEATS; b++) q.push_back('{kind: K_WR, addr: r*BEATS + b, row: r});
    end
    @(negedge clk);
    cmd_start = 1'b1;
    cmd_num_rows = 7'(n);
    if (busy > 0) ln_busy = 1'b1;
    acc = cyc;
    @(negedge clk);
    cmd_start = 1'b0;
    got = 0;
    lat = -1;
    for (int k = 0; k < 20000 && !got; k++) begin
      off = cyc - acc;
      if (busy > 0 && off == 18 + busy) ln_busy = 1'b0;
      if (poke > 0 && off == poke) begin
        cmd_start = 1'b1;
        cmd_num_rows = 7'd5;
      end
      if (poke > 0 && off == poke + 1) cmd_start = 1'b0;
      if (cmd_done) begin
        got = 1;
        lat = off;
        check("busy_at_done", cmd_busy, 1);
      end else @(negedge clk);
    end
    check("done_seen", got, 1);
    check("done_latency", lat, (neff == 0) ? 1 : neff*(34 + t) + busy + 1);
    @(negedge clk);
    check("busy_after_done", cmd_busy, 0);
    check("done_one_cycle", cmd_done, 0);
    check("events_left", q.size(), 0);
    q.delete();
    dl = n_ln - ln0; dr = n_rd - rd0; dw = n_wr - wr0;
  endtask

  initial begin
    int acc, lat, dl, dr, dw, wr0;
    // Reset and idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_strobes", {cmd_busy, cmd_done, rd_en, ln_start, wr_en}, 5'b0);
    end
    check("reset_addrs", {rd_addr, wr_addr}, '0);
    check("reset_x_bad_elems", count_bad(ln_x_flat, '0), 0);

    // Reset in the middle of WAIT: result discarded, later done ignored.
    ln_lat = 40; ln_len = 1;
    for (int b = 0; b < BEATS; b++) q.push_back('{kind: K_RD, addr: b, row: 0});
    q.push_back('{kind: K_LN, addr: -1, row: 0});
    @(negedge clk);
    cmd_start = 1'b1; cmd_num_rows = 7'd1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (28) @(negedge clk);
    check("pre_reset_events_left", q.size(), 0);
    q.delete();
    in_wait = 0;
    wr0 = n_wr;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", cmd_busy, 0);
    check("rst_mid_x_bad_elems", count_bad(ln_x_flat, '0), 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("rst_mid_quiet", {cmd_busy, cmd_done, wr_en}, 3'b0);
    end
    check("rst_mid_no_writes", n_wr - wr0, 0);

    // One row, T_ln = 40.
    first_wr_seen = 0;
    run_cmd(1, 40, 1, 0, 0, acc, lat, dl, dr, dw);
    check("one_row_latency", lat, 75);
    check("one_row_ln_starts", dl, 1);
    check("one_row_reads", dr, 16);
    check("one_row_writes", dw, 16);
    check("one_row_first_wr", first_wr[47:0], {16'd3, 16'd2, 16'd1});

    // Three rows.
    run_cmd(3, 40, 1, 0, 0, acc, lat, dl, dr, dw);
    check("three_row_latency", lat, 223);
    check("three_row_ln_starts", dl, 3);
    check("three_row_reads", dr, 48);
    check("three_row_writes", dw, 48);

    // LayerNorm busy for 20 cycles at ISSUE.
    run_cmd(1, 10, 1, 20, 0, acc, lat, dl, dr, dw);
    check("busy_ln_start_cycle", last_ln_cyc - acc, 38);
    check("busy_ln_starts", dl, 1);

    // Zero rows.
    run_cmd(0, 10, 1, 0, 0, acc, lat, dl, dr, dw);
    check("zero_latency", lat, 1);
    check("zero_activity", {dl[7:0], dr[7:0], dw[7:0]}, 24'h0);

    // Start poked during STORE of row 0, done held 3 cycles.
    run_cmd(2, 40, 3, 0, 65, acc, lat, dl, dr, dw);
    check("poke_latency", lat, 149);
    check("poke_writes", dw, 32);

    // Row count above the maximum is clamped.
    run_cmd(100, 2, 1, 0, 0, acc, lat, dl, dr, dw);
    check("clamp_ln_starts", dl, 64);
    check("clamp_writes", dw, 1024);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
